// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: HI/LO funct codes and the
// multiply/divide sequencer types.
package mips_pkg;

  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } muldiv_state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } muldiv_op_t;

endpackage

// File: rtl/hilo_iter_datapath.sv
// Bit-serial multiply/divide datapath: one shift-add (multiply) or one
// restoring shift-subtract (divide) step per enabled cycle on unsigned magnitudes.
module hilo_iter_datapath
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  muldiv_op_t         op,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0]   opnd_r;
  muldiv_op_t         op_r;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH:0]     diff_s;

  // Next accumulator value for one iteration of the latched operation.
  // Multiply keeps the multiplier in the low half and shifts the product in
  // from the top; divide shifts the dividend out of the low half into the
  // remainder while quotient bits fill in from bit 0.
  always_comb begin
    add_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
               + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    trial_s    = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    diff_s     = trial_s - {1'b0, opnd_r};
    acc_next_s = acc_r;
    case (op_r)
      OP_MUL: acc_next_s = {add_s, acc_r[WIDTH-1:1]};
      OP_DIV: begin
        if (!diff_s[WIDTH]) begin
          acc_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
          acc_next_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
      end
      default: acc_next_s = acc_r;
    endcase
  end

  // Operand load on acceptance, then one iteration per step cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r  <= {(2*WIDTH){1'b0}};
      opnd_r <= {WIDTH{1'b0}};
      op_r   <= OP_MUL;
    end else if (load) begin
      op_r <= op;
      if (op == OP_MUL) begin
        acc_r  <= {{WIDTH{1'b0}}, b_mag};
        opnd_r <= a_mag;
      end else begin
        acc_r  <= {{WIDTH{1'b0}}, a_mag};
        opnd_r <= b_mag;
      end
    end else if (step) begin
      acc_r <= acc_next_s;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair;
// also services MTHI/MTLO writes while idle.
module hilo_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t      state_r, state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r, done_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  muldiv_op_t         op_r, op_s;
  logic               neg_res_r, neg_rem_r, div_zero_r;
  logic               is_mul_s, is_div_s, is_signed_s, rs_neg_s, rt_neg_s;
  logic [WIDTH-1:0]   rs_mag_s, rt_mag_s;
  logic               accept_s, step_s, commit_s, mthi_s, mtlo_s;
  logic [2*WIDTH-1:0] acc_s, prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s, res_hi_s, res_lo_s;

  // Request decode and operand magnitudes.
  always_comb begin
    is_mul_s    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    is_div_s    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    is_signed_s = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    op_s        = is_div_s ? OP_DIV : OP_MUL;
    rs_neg_s    = is_signed_s & rs_content[WIDTH-1];
    rt_neg_s    = is_signed_s & rt_content[WIDTH-1];
    rs_mag_s    = rs_neg_s ? ({WIDTH{1'b0}} - rs_content) : rs_content;
    rt_mag_s    = rt_neg_s ? ({WIDTH{1'b0}} - rt_content) : rt_content;
    mthi_s      = (state_r == IDLE) && start && (funct == FUNCT_MTHI);
    mtlo_s      = (state_r == IDLE) && start && (funct == FUNCT_MTLO);
  end

  // Sequencer next-state and control strobes.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    step_s       = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && (is_mul_s || is_div_s)) begin
          accept_s     = 1'b1;
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        step_s = 1'b1;
        if (cnt_r == {CNT_W{1'b1}}) begin
          state_next_s = FINISH;
        end else begin
          state_next_s = CALC;
        end
      end
      FINISH: begin
        commit_s     = 1'b1;
        state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  hilo_iter_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept_s),
    .step  (step_s),
    .op    (op_s),
    .a_mag (rs_mag_s),
    .b_mag (rt_mag_s),
    .acc   (acc_s)
  );

  // Sign fixup. Negating the divide-by-zero remainder restores the raw
  // dividend, so only the quotient needs forcing to all ones.
  always_comb begin
    prod_s = neg_res_r ? ({(2*WIDTH){1'b0}} - acc_s) : acc_s;
    quot_s = acc_s[WIDTH-1:0];
    rem_s  = acc_s[2*WIDTH-1:WIDTH];
    case (op_r)
      OP_MUL: begin
        res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_s[WIDTH-1:0];
      end
      OP_DIV: begin
        res_hi_s = neg_rem_r ? ({WIDTH{1'b0}} - rem_s) : rem_s;
        if (div_zero_r) begin
          res_lo_s = {WIDTH{1'b1}};
        end else begin
          res_lo_s = neg_res_r ? ({WIDTH{1'b0}} - quot_s) : quot_s;
        end
      end
      default: begin
        res_hi_s = hi_r;
        res_lo_s = lo_r;
      end
    endcase
  end

  // State, counter, sign flags and the HI/LO architectural registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      op_r       <= OP_MUL;
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= commit_s;
      if (accept_s) begin
        cnt_r      <= {CNT_W{1'b0}};
        op_r       <= op_s;
        neg_res_r  <= rs_neg_s ^ rt_neg_s;
        neg_rem_r  <= rs_neg_s;
        div_zero_r <= is_div_s && (rt_content == {WIDTH{1'b0}});
      end else if (step_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (commit_s) begin
        hi_r <= res_hi_s;
        lo_r <= res_lo_s;
      end else begin
        if (mthi_s) hi_r <= rs_content;
        if (mtlo_s) lo_r <= rs_content;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed-vector bench for hilo_muldiv_unit: latency, results, HI/LO moves,
// ignored starts and mid-operation reset.
module tb_hilo_muldiv_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] rs_content, rt_content;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .funct      (funct),
    .rs_content (rs_content),
    .rt_content (rt_content),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge (edge k) and
  // the task returns at the negedge of cycle k+1.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start      = 1'b1;
    funct      = f;
    rs_content = a;
    rt_content = b;
    @(negedge clk);
    start      = 1'b0;
    funct      = 6'h00;
    rs_content = 32'h0;
    rt_content = 32'h0;
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cycles;
    int gaps;
    issue(f, a, b);
    cycles = 1;
    gaps   = 0;
    while (!done && cycles < 40) begin
      if (!busy) gaps++;
      @(negedge clk);
      cycles++;
    end
    check_eq({tag, " latency"}, 32'(cycles), 32'd34);
    check_eq({tag, " busy gaps"}, 32'(gaps), 32'd0);
    check_eq({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    check_eq({tag, " hi"}, hi, exp_hi);
    check_eq({tag, " lo"}, lo, exp_lo);
  endtask

  task automatic wait_done(input string tag);
    int cycles;
    cycles = 0;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check_eq({tag, " done seen"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int dcount;
    rst_n      = 1'b0;
    start      = 1'b0;
    funct      = 6'h00;
    rs_content = 32'h0;
    rt_content = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("reset busy", {31'd0, busy}, 32'd0);
    check_eq("reset done", {31'd0, done}, 32'd0);
    check_eq("reset hi", hi, 32'h0);
    check_eq("reset lo", lo, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("multu max", FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult -3*7", FUNCT_MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div -7/2 b2b", FUNCT_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("mult -2*-3", FUNCT_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006);
    run_op("div 7/-2", FUNCT_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu big/16", FUNCT_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);
    run_op("divu 7/0", FUNCT_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
    run_op("div -5/0", FUNCT_DIV, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("div ovf", FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    issue(FUNCT_MTHI, 32'h12345678, 32'h0);
    check_eq("mthi hi", hi, 32'h12345678);
    check_eq("mthi lo kept", lo, 32'h80000000);
    check_eq("mthi busy", {31'd0, busy}, 32'd0);
    issue(FUNCT_MTLO, 32'h9ABCDEF0, 32'h0);
    check_eq("mtlo lo", lo, 32'h9ABCDEF0);
    check_eq("mtlo hi kept", hi, 32'h12345678);
    check_eq("mtlo busy", {31'd0, busy}, 32'd0);
    check_eq("mtlo done", {31'd0, done}, 32'd0);

    issue(6'h20, 32'h11111111, 32'h22222222);
    check_eq("bad funct busy", {31'd0, busy}, 32'd0);
    check_eq("bad funct hi", hi, 32'h12345678);

    issue(FUNCT_MULTU, 32'h00010000, 32'h00030000);
    repeat (3) @(negedge clk);
    issue(FUNCT_MTHI, 32'hDEADBEEF, 32'h0);
    check_eq("busy mthi ignored", hi, 32'h12345678);
    check_eq("busy during calc", {31'd0, busy}, 32'd1);
    wait_done("multu w/ mthi");
    check_eq("multu w/ mthi hi", hi, 32'h00000003);
    check_eq("multu w/ mthi lo", lo, 32'h00000000);

    @(negedge clk);
    issue(FUNCT_DIVU, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mid rst busy", {31'd0, busy}, 32'd0);
    check_eq("mid rst hi", hi, 32'h0);
    check_eq("mid rst lo", lo, 32'h0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check_eq("mid rst no done", 32'(dcount), 32'd0);
    run_op("multu 3*5", FUNCT_MULTU, 32'd3, 32'd5, 32'h0, 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
